ifmap_release_ctrl: RTL and testbench
=====================================

Name: ifmap_release_ctrl

Overview:
Parametrised successor to the PE-completion/ifmap-free logic in the NOC. It counts `complete` pulses from the PE array. Every N completions, where N is selected per layer type, it generates one "free" event for the ifmap buffer. Free events are queued and delivered to the buffer manager over a valid/ready handshake, carrying a round-robin bank index. The block also tracks a per-layer total and signals layer completion once every expected free has been delivered.

Parameters:
- NUM_BANKS, 2: number of ifmap buffer banks; `free_bank` cycles 0..NUM_BANKS-1.
- MAX_PENDING, 4: depth of the pending-free counter; must be >= 1.
- L1_CPF, 2: completions per free in LAYER1.
- L2_CPF, 4: completions per free in LAYER2.
- L3_CPF, 1: completions per free in LAYER3; every CPF must be >= 1.
- FREE_CNT_W, 8: width of the free total and free counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  synchronous pulse; latches config and begins a layer
- layer_type_in  in  LAYER_TYPE  layer selector, sampled on `start`
- cfg_frees_total  in  FREE_CNT_W  expected frees for this layer, sampled on `start`
- complete  in  1  one-cycle pulse from the PE array
- free_valid  out  1  a free event is pending
- free_bank  out  max(1,$clog2(NUM_BANKS))  bank to release
- free_ready  in  1  buffer manager accepts the free
- busy  out  1  state is RUN or DRAIN
- layer_done  out  1  one-cycle pulse when the layer finishes
- overflow_err  out  1  sticky flag: a free was dropped because pending was full
- frees_issued  out  FREE_CNT_W  handshakes completed in the current layer

Behaviour:
- Reset is asynchronous, active-low. All outputs are 0. State=IDLE. Every counter and the bank pointer are 0.
- States: IDLE, RUN, DRAIN, DONE.
- `start` in any state:
  - Clears complete_cnt, pending, gen_cnt, frees_issued, bank_ptr and overflow_err.
  - Latches layer_type_in (to thr select) and cfg_frees_total.
  - Next state is RUN, or DONE if cfg_frees_total==0; in that case layer_done pulses the next cycle.
  - `start` has priority: any `complete` or handshake in the same cycle is discarded.
- thr = L1_CPF, L2_CPF or L3_CPF according to the latched layer type.
- `complete` in RUN:
  - If complete_cnt == thr-1: complete_cnt wraps to 0 and a free is generated (gen_cnt++, pending++).
  - Otherwise complete_cnt++.
- `complete` in IDLE, DRAIN or DONE is ignored with no side effect.
- Generation when pending == MAX_PENDING with no simultaneous handshake: the free is dropped, overflow_err is set, and gen_cnt still increments so layer accounting terminates.
- Handshake:
  - free_valid = (pending != 0), driven directly from the register.
  - Latency: a completing pulse in cycle N gives free_valid=1 in cycle N+1.
  - free_bank = bank_ptr.
  - On free_valid && free_ready: pending--, frees_issued++, and bank_ptr increments modulo NUM_BANKS (wraps NUM_BANKS-1 -> 0).
  - free_bank is held stable while free_valid && !free_ready.
  - Generation and handshake in the same cycle: pending is unchanged, including when pending is at MAX_PENDING (no overflow).
- RUN -> DRAIN when a generation makes gen_cnt == cfg_frees_total. From that point further `complete` pulses are ignored.
- DRAIN -> DONE in the cycle after pending reaches 0. layer_done pulses for exactly one cycle on entry to DONE.
- DONE holds until `start` or reset. free_valid=0 in DONE.
- busy = (state==RUN || state==DRAIN).
- Counter widths:
  - complete_cnt: $clog2(max CPF)+1 bits.
  - pending: $clog2(MAX_PENDING+1) bits.
  - frees_issued and gen_cnt: no wrap within a layer, since they are bounded by cfg_frees_total.
- Reset asserted mid-layer aborts immediately to the reset values. No free is retained.

Decomposition:
- Shared package (the existing NOC types package):
  - LAYER_TYPE enum {LAYER1, LAYER2, LAYER3}.
  - Default CPF constants L1=2, L2=4, L3=1.
  - State enum for this block.
- One natural sub-module: `free_credit_queue`. It holds the pending counter, bank_ptr and the valid/ready handshake, with inputs push/pop and outputs valid/bank/full/overflow.
- The top level holds the FSM, threshold selection and the completion counter.

Test Plan:
1. LAYER2, total=2, free_ready=1, 8 complete pulses spaced 2 cycles apart: free_valid pulses one cycle after the 4th and after the 8th pulse; free_bank 0 then 1; layer_done one cycle after the second handshake; frees_issued=2.
2. LAYER1, total=3, free_ready=0, 6 completes: pending reaches 3, free_bank stays 0 throughout. Then ready=1 for 3 cycles: banks 0,1,0; layer_done pulses once.
3. LAYER3, MAX_PENDING=4, total=6, ready=0, 6 completes: overflow_err=1 after the 5th complete and pending=4. Release with ready=1: 4 handshakes, then DONE.
4. `start` asserted together with `complete` mid-RUN: the complete is ignored; counters and overflow_err are cleared; the new layer type takes effect. Also: start with total=0 gives layer_done 1 cycle later and free_valid never asserts.
5. Completes arriving in DRAIN and DONE, plus generation and handshake in the same cycle at pending=MAX_PENDING: the extra completes have no effect; pending is unchanged and overflow_err stays 0.
6. rst_n dropped mid-DRAIN with pending=2: all outputs are 0 asynchronously; after release, state is IDLE and free_valid=0.

Source files
------------

// File: rtl/ifmap_release_ctrl_pkg.sv
// Shared NOC types for the ifmap release controller: layer selector, default
// completions-per-free and the controller state encoding.
package ifmap_release_ctrl_pkg;

  typedef enum logic [1:0] {
    LAYER1 = 2'd0,
    LAYER2 = 2'd1,
    LAYER3 = 2'd2
  } layer_type_e;

  localparam int unsigned DefL1Cpf = 2;
  localparam int unsigned DefL2Cpf = 4;
  localparam int unsigned DefL3Cpf = 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } release_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/free_credit_queue.sv
// Pending-free credit counter with round-robin bank pointer and valid/ready
// delivery towards the ifmap buffer manager.
module free_credit_queue #(
  parameter int unsigned NumBanks   = 2,
  parameter int unsigned MaxPending = 4,
  parameter int unsigned BankW      = 1,
  parameter int unsigned PendW      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [BankW-1:0] bank_o,
  output logic             pop_o,
  output logic             overflow_o,
  output logic             drain_last_o
);

  logic [PendW-1:0] pending_q, pending_d;
  logic [BankW-1:0] bank_q, bank_d;
  logic             overflow_q, overflow_d;
  logic             full;
  logic             pop;

  assign valid_o = (pending_q != '0);
  assign full    = (pending_q == PendW'(MaxPending));
  // A clear discards any handshake offered in the same cycle.
  assign pop     = valid_o && ready_i && !clr_i;

  always_comb begin
    pending_d  = pending_q;
    bank_d     = bank_q;
    overflow_d = overflow_q;
    if (clr_i) begin
      pending_d  = '0;
      bank_d     = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_i && !pop) begin
        if (full) overflow_d = 1'b1;
        else      pending_d  = pending_q + 1'b1;
      end else if (pop && !push_i) begin
        pending_d = pending_q - 1'b1;
      end
      if (pop) begin
        bank_d = (bank_q == BankW'(NumBanks - 1)) ? '0 : bank_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      bank_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      bank_q     <= bank_d;
      overflow_q <= overflow_d;
    end
  end

  assign bank_o       = bank_q;
  assign pop_o        = pop;
  assign overflow_o   = overflow_q;
  // Queue empties this cycle assuming no push; only consulted while draining.
  assign drain_last_o = (pending_q == '0) || ((pending_q == PendW'(1)) && pop);

endmodule

// File: rtl/ifmap_release_ctrl.sv
// Counts PE completions, turns every N of them into an ifmap free event and
// tracks per-layer progress until all expected frees have been delivered.
module ifmap_release_ctrl
  import ifmap_release_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned MAX_PENDING = 4,
  parameter int unsigned L1_CPF      = DefL1Cpf,
  parameter int unsigned L2_CPF      = DefL2Cpf,
  parameter int unsigned L3_CPF      = DefL3Cpf,
  parameter int unsigned FREE_CNT_W  = 8,
  localparam int unsigned BankW      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  layer_type_e           layer_type_in,
  input  logic [FREE_CNT_W-1:0] cfg_frees_total,
  input  logic                  complete,
  output logic                  free_valid,
  output logic [BankW-1:0]      free_bank,
  input  logic                  free_ready,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  overflow_err,
  output logic [FREE_CNT_W-1:0] frees_issued
);

  localparam int unsigned MaxCpf = max3(L1_CPF, L2_CPF, L3_CPF);
  localparam int unsigned CntW   = $clog2(MaxCpf) + 1;
  localparam int unsigned PendW  = $clog2(MAX_PENDING + 1);

  release_state_e        state_q, state_d;
  layer_type_e           layer_q, layer_d;
  logic [FREE_CNT_W-1:0] total_q, total_d;
  logic [FREE_CNT_W-1:0] gen_q, gen_d;
  logic [FREE_CNT_W-1:0] issued_q, issued_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  layer_done_q, layer_done_d;
  logic [CntW-1:0]       thr;
  logic                  push;
  logic                  pop;
  logic                  drain_last;

  always_comb begin
    case (layer_q)
      LAYER1:  thr = CntW'(L1_CPF);
      LAYER2:  thr = CntW'(L2_CPF);
      default: thr = CntW'(L3_CPF);
    endcase
  end

  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    total_d      = total_q;
    gen_d        = gen_q;
    issued_d     = issued_q;
    cnt_d        = cnt_q;
    layer_done_d = 1'b0;
    push         = 1'b0;
    if (start) begin
      layer_d      = layer_type_in;
      total_d      = cfg_frees_total;
      gen_d        = '0;
      issued_d     = '0;
      cnt_d        = '0;
      state_d      = (cfg_frees_total == '0) ? StDone : StRun;
      layer_done_d = (cfg_frees_total == '0);
    end else begin
      if (pop) issued_d = issued_q + 1'b1;
      unique case (state_q)
        StRun: begin
          if (complete) begin
            if (cnt_q == thr - 1'b1) begin
              cnt_d = '0;
              push  = 1'b1;
              // Counted even if the queue drops it, so the layer still ends.
              gen_d = gen_q + 1'b1;
              if (gen_d == total_q) state_d = StDrain;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (drain_last) begin
            state_d      = StDone;
            layer_done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      layer_q      <= LAYER1;
      total_q      <= '0;
      gen_q        <= '0;
      issued_q     <= '0;
      cnt_q        <= '0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      total_q      <= total_d;
      gen_q        <= gen_d;
      issued_q     <= issued_d;
      cnt_q        <= cnt_d;
      layer_done_q <= layer_done_d;
    end
  end

  free_credit_queue #(
    .NumBanks  (NUM_BANKS),
    .MaxPending(MAX_PENDING),
    .BankW     (BankW),
    .PendW     (PendW)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (start),
    .push_i      (push),
    .ready_i     (free_ready),
    .valid_o     (free_valid),
    .bank_o      (free_bank),
    .pop_o       (pop),
    .overflow_o  (overflow_err),
    .drain_last_o(drain_last)
  );

  assign busy         = (state_q == StRun) || (state_q == StDrain);
  assign layer_done   = layer_done_q;
  assign frees_issued = issued_q;

endmodule

// File: tb/tb_ifmap_release_ctrl.sv
// Directed and randomized bench for ifmap_release_ctrl against a cycle-level
// behavioural model of the layer/free accounting.
module tb_ifmap_release_ctrl;
  import ifmap_release_ctrl_pkg::*;

  localparam int unsigned NB = 2;
  localparam int unsigned MP = 4;
  localparam int unsigned FW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          complete = 1'b0;
  logic          free_ready = 1'b0;
  layer_type_e   layer_type_in = LAYER1;
  logic [FW-1:0] cfg_frees_total = '0;
  logic          free_valid;
  logic [0:0]    free_bank;
  logic          busy;
  logic          layer_done;
  logic          overflow_err;
  logic [FW-1:0] frees_issued;

  int n_cmp = 0;
  int n_fail = 0;
  int seen_done = 0;

  // Model: phase 0 idle, 1 run, 2 drain, 3 done.
  int m_phase, m_cnt, m_pend, m_gen, m_iss, m_bank, m_ovf, m_done, m_thr, m_total;

  always #5 clk = ~clk;

  ifmap_release_ctrl #(
    .NUM_BANKS  (NB),
    .MAX_PENDING(MP),
    .L1_CPF     (2),
    .L2_CPF     (4),
    .L3_CPF     (1),
    .FREE_CNT_W (FW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .layer_type_in  (layer_type_in),
    .cfg_frees_total(cfg_frees_total),
    .complete       (complete),
    .free_valid     (free_valid),
    .free_bank      (free_bank),
    .free_ready     (free_ready),
    .busy           (busy),
    .layer_done     (layer_done),
    .overflow_err   (overflow_err),
    .frees_issued   (frees_issued)
  );

  function automatic int cpf(input layer_type_e l);
    case (l)
      LAYER1:  return 2;
      LAYER2:  return 4;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_pend = 0; m_gen = 0; m_iss = 0;
    m_bank = 0; m_ovf = 0; m_done = 0; m_thr = 2; m_total = 0;
  endtask

  task automatic model_step(input logic s, input logic c, input logic r);
    int old_phase;
    bit hs, gen;
    old_phase = m_phase;
    m_done = 0;
    if (s) begin
      m_cnt = 0; m_pend = 0; m_gen = 0; m_iss = 0; m_bank = 0; m_ovf = 0;
      m_thr = cpf(layer_type_in);
      m_total = int'(cfg_frees_total);
      m_phase = (m_total == 0) ? 3 : 1;
      m_done = (m_total == 0) ? 1 : 0;
    end else begin
      hs = (m_pend > 0) && r;
      gen = 0;
      if (m_phase == 1 && c) begin
        m_cnt++;
        if (m_cnt == m_thr) begin
          m_cnt = 0;
          gen = 1;
        end
      end
      if (gen) begin
        m_gen++;
        if (m_gen == m_total) m_phase = 2;
      end
      if (gen && !hs) begin
        if (m_pend == MP) m_ovf = 1;
        else m_pend++;
      end else if (hs && !gen) begin
        m_pend--;
      end
      if (hs) begin
        m_iss++;
        m_bank = (m_bank + 1) % NB;
      end
      if (old_phase == 2 && m_pend == 0) begin
        m_phase = 3;
        m_done = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("free_valid", 32'(free_valid), 32'(m_pend > 0));
    chk("free_bank", 32'(free_bank), 32'(m_bank));
    chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
    chk("layer_done", 32'(layer_done), 32'(m_done));
    chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
    chk("frees_issued", 32'(frees_issued), 32'(m_iss));
    seen_done += int'(layer_done);
  endtask

  task automatic tick(input logic s, input logic c, input logic r);
    @(negedge clk);
    check_outputs();
    start = s;
    complete = c;
    free_ready = r;
    @(posedge clk);
    model_step(s, c, r);
  endtask

  task automatic begin_layer(input layer_type_e l, input int total, input logic c,
                             input logic r);
    layer_type_in = l;
    cfg_frees_total = FW'(total);
    tick(1'b1, c, r);
  endtask

  initial begin
    int cycles;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 1'b1);

    // 1: LAYER2, two frees, ready always high.
    seen_done = 0;
    begin_layer(LAYER2, 2, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    #1;
    chk("t1_issued", 32'(frees_issued), 32'd2);
    chk("t1_done_pulses", 32'(seen_done), 32'd1);

    // 2: LAYER1, backpressure then release.
    seen_done = 0;
    begin_layer(LAYER1, 3, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b1, 1'b0);
    #1;
    chk("t2_bank_held", 32'(free_bank), 32'd0);
    chk("t2_valid_held", 32'(free_valid), 32'd1);
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    #1;
    chk("t2_issued", 32'(frees_issued), 32'd3);
    chk("t2_done_pulses", 32'(seen_done), 32'd1);

    // 3: LAYER3 overflow.
    begin_layer(LAYER3, 6, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    #1;
    chk("t3_overflow", 32'(overflow_err), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    repeat (5) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    #1;
    chk("t3_issued", 32'(frees_issued), 32'd4);

    // 4: start colliding with complete and handshake mid-run, then an empty layer.
    begin_layer(LAYER3, 8, 1'b0, 1'b0);
    repeat (5) tick(1'b0, 1'b1, 1'b0);
    begin_layer(LAYER2, 1, 1'b1, 1'b1);
    #1;
    chk("t4_ovf_cleared", 32'(overflow_err), 32'd0);
    chk("t4_valid_cleared", 32'(free_valid), 32'd0);
    repeat (3) tick(1'b0, 1'b1, 1'b0);
    #1;
    chk("t4_no_free_yet", 32'(free_valid), 32'd0);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    seen_done = 0;
    begin_layer(LAYER1, 0, 1'b0, 1'b1);
    #1;
    chk("t4_zero_done", 32'(layer_done), 32'd1);
    repeat (4) tick(1'b0, 1'b1, 1'b1);
    chk("t4_zero_done_pulses", 32'(seen_done), 32'd1);

    // 5: simultaneous generate+handshake at full, completes in DRAIN/DONE.
    begin_layer(LAYER3, 6, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_no_overflow", 32'(overflow_err), 32'd0);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, logic'(i % 2));
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    #1;
    chk("t5_issued", 32'(frees_issued), 32'd6);
    chk("t5_ovf_final", 32'(overflow_err), 32'd0);

    // 6: asynchronous reset mid-drain.
    begin_layer(LAYER1, 2, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(free_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_bank", 32'(free_bank), 32'd0);
    chk("t6_issued", 32'(frees_issued), 32'd0);
    chk("t6_done", 32'(layer_done), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick(1'b0, 1'b1, 1'b1);

    // Randomized layers.
    for (int l = 0; l < 8; l++) begin
      begin_layer(layer_type_e'($urandom_range(0, 2)), 1 + int'($urandom_range(0, 7)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      cycles = 0;
      while (m_phase != 3 && cycles < 400) begin
        tick(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
        cycles++;
      end
      chk("rand_layer_finished", 32'(m_phase), 32'd3);
      repeat (2) tick(1'b0, logic'($urandom_range(0, 1)), 1'b1);
    end

    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
